// File: rtl/mcu_bus_slave.sv
// mcu_bus_slave: slave end of the MCU multiplexed 8-bit address/data bus feeding the register file
// Ports: clk/rst_n (async active-low); ale/read/write active-low MCU strobes; data shared bus;
//        reg_addr/reg_wdata/reg_we/reg_re/reg_rdata register-file side; bus_err sticky protocol error.
// Define MCU_BUS_ERR_EN to build bus_err detection; otherwise bus_err is tied 0.
`timescale 1ns/1ps
module mcu_bus_slave #(
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] ERR_CLR_ADDR = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ale,
  input  logic       read,
  input  logic       write,
  inout  wire  [7:0] data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       bus_err
);
  typedef enum logic [2:0] {IDLE, ADDR, ARMED, WR, RD} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] ale_q, read_q, write_q;
  logic [SYNC_STAGES-1:0][7:0] data_q;
  logic ale_s, read_s, write_s;
  logic [7:0] data_s, rd_hold;
  logic addr_ld, wd_ld, we_nx, re_nx;
  // data runs through the same depth as the strobes so data_s lines up with them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ale_q <= '1;
      read_q <= '1;
      write_q <= '1;
      data_q <= '0;
    end else begin
      ale_q <= {ale_q[SYNC_STAGES-2:0], ale};
      read_q <= {read_q[SYNC_STAGES-2:0], read};
      write_q <= {write_q[SYNC_STAGES-2:0], write};
      data_q <= {data_q[SYNC_STAGES-2:0], data};
    end
  assign ale_s = ale_q[SYNC_STAGES-1];
  assign read_s = read_q[SYNC_STAGES-1];
  assign write_s = write_q[SYNC_STAGES-1];
  assign data_s = data_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // write has priority over read when both strobes are low
  always_comb
    case (state)
      IDLE:    state_nx = ale_s ? IDLE : ADDR;
      ADDR:    state_nx = ale_s ? ARMED : ADDR;
      ARMED:   state_nx = !write_s ? WR : !read_s ? RD : !ale_s ? ADDR : ARMED;
      WR:      state_nx = write_s ? ARMED : WR;
      RD:      state_nx = read_s ? ARMED : RD;
      default: state_nx = IDLE;
    endcase
  always_comb begin
    addr_ld = state == ADDR && !ale_s;
    wd_ld = state == WR && !write_s;
    we_nx = state == WR && write_s;
    re_nx = state == RD && read_s;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      reg_addr <= '0;
      reg_wdata <= '0;
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      rd_hold <= '0;
    end else begin
      if (addr_ld) reg_addr <= data_s;
      if (wd_ld) reg_wdata <= data_s;
      reg_we <= we_nx;
      reg_re <= re_nx;
      if (read_s) rd_hold <= reg_rdata;
    end
  // enable comes straight from the pins so the bus turns around without sync delay
  assign data = (rst_n && !read && ale) ? rd_hold : 'z;
`ifdef MCU_BUS_ERR_EN
  logic read_p, write_p, err_set, err_clr;
  always_comb begin
    err_set = (!read_s && !write_s) || (state == IDLE && ((read_p && !read_s) || (write_p && !write_s)));
    err_clr = reg_we && reg_addr == ERR_CLR_ADDR;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      read_p <= 1'b1;
      write_p <= 1'b1;
      bus_err <= 1'b0;
    end else begin
      read_p <= read_s;
      write_p <= write_s;
      bus_err <= err_set || (bus_err && !err_clr);
    end
`else
  logic err_unused;
  assign err_unused = ^ERR_CLR_ADDR;
  assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_mcu_bus_slave.sv
// tb_mcu_bus_slave: scoreboard bench for mcu_bus_slave driving MCU bus cycles
`timescale 1ns/1ps
module tb_mcu_bus_slave;
  localparam int SS = 2;
  localparam int T = 68;
  typedef struct packed {
    logic is_we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ale = 1'b1;
  logic read = 1'b1;
  logic write = 1'b1;
  logic drv_en = 1'b0;
  logic [7:0] drv_val = 8'h00;
  wire [7:0] data;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic reg_we, reg_re, bus_err;
  int checks = 0;
  int fails = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  time t_wr = 0;
  time d;
  ev_t e;
  ev_t exp_q[$];
  assign data = drv_en ? drv_val : 'z;
  assign reg_rdata = (reg_addr == 8'h12) ? 8'hA7 : reg_addr ^ 8'h5A;
  always #34 clk = ~clk;
  mcu_bus_slave #(.SYNC_STAGES(SS), .ERR_CLR_ADDR(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .ale(ale), .read(read), .write(write), .data(data),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .bus_err(bus_err)
  );
  always @(negedge clk) begin
    if (reg_we || reg_re) begin
      checks++;
      if (reg_we && reg_re) begin
        fails++;
        $display("FAIL strobe_overlap: we=%b re=%b, want never both", reg_we, reg_re);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: we=%b re=%b addr=%h, want none", reg_we, reg_re, reg_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.is_we != reg_we || e.addr != reg_addr || (reg_we && e.wdata != reg_wdata)) begin
          fails++;
          $display("FAIL pulse: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                   reg_we, reg_addr, reg_wdata, e.is_we, e.addr, e.wdata);
        end
      end
      if (reg_we) begin
        we_cnt++;
        checks++;
        d = $time - T/2 - t_wr;
        if (d <= SS*T || d > (SS+1)*T) begin
          fails++;
          $display("FAIL we_latency: got %0d ns, want in (%0d,%0d]", d, SS*T, (SS+1)*T);
        end
      end else re_cnt++;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic addr_phase(input logic [7:0] a);
    ale = 1'b0;
    drv_en = 1'b1;
    drv_val = a;
    #(3*T);
    ale = 1'b1;
    #51;
  endtask
  task automatic bus_write(input logic [7:0] a, input logic [7:0] v);
    exp_q.push_back({1'b1, a, v});
    addr_phase(a);
    drv_val = v;
    write = 1'b0;
    #(3*T);
    write = 1'b1;
    t_wr = $time;
    #51;
  endtask
  task automatic bus_read(input logic [7:0] a, input logic [7:0] v);
    exp_q.push_back({1'b0, a, 8'h00});
    addr_phase(a);
    drv_en = 1'b0;
    #((SS+3)*T);
    read = 1'b0;
    #(4*T);
    chk("read_data", {24'h0, data}, {24'h0, v});
    read = 1'b1;
    #51;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, {24'h0, reg_addr}, 0);
    chk({tag, "_wdata"}, {24'h0, reg_wdata}, 0);
    chk({tag, "_we"}, {31'h0, reg_we}, 0);
    chk({tag, "_re"}, {31'h0, reg_re}, 0);
    chk({tag, "_err"}, {31'h0, bus_err}, 0);
  endtask
  initial begin
    logic err_exp;
`ifdef MCU_BUS_ERR_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    #(3*T);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #10;
    bus_write(8'h10, 8'hE5);
    #(4*T);
    chk("t1_we_count", we_cnt, 1);
    chk("t1_re_count", re_cnt, 0);
    @(negedge clk);
    #10;
    bus_write(8'h10, 8'hE5);
    bus_read(8'h12, 8'hA7);
    #(4*T);
    chk("t2_we_count", we_cnt, 2);
    chk("t2_re_count", re_cnt, 1);
    @(negedge clk);
    #10;
    bus_write(8'h00, 8'h01);
    bus_write(8'h01, 8'h80);
    #(4*T);
    chk("t3_we_count", we_cnt, 4);
    chk("t3_addr_held", {24'h0, reg_addr}, 32'h01);
    chk("t3_wdata_held", {24'h0, reg_wdata}, 32'h80);
    @(negedge clk);
    #10;
    addr_phase(8'h20);
    drv_val = 8'h55;
    write = 1'b0;
    #(3*T);
    rst_n = 1'b0;
    #(2*T);
    chk_zero("t4_rst");
    rst_n = 1'b1;
    #(2*T);
    write = 1'b1;
    #(4*T);
    chk("t4_no_we", we_cnt, 4);
    bus_write(8'h20, 8'h55);
    #(4*T);
    chk("t4_we_after", we_cnt, 5);
    @(negedge clk);
    #10;
    addr_phase(8'h30);
    drv_en = 1'b0;
    exp_q.push_back({1'b1, 8'h30, 8'h6A});
    read = 1'b0;
    write = 1'b0;
    #(3*T);
    read = 1'b1;
    write = 1'b1;
    t_wr = $time;
    #(4*T);
    chk("t5_we_count", we_cnt, 6);
    chk("t5_re_count", re_cnt, 1);
    chk("t5_err_set", {31'h0, bus_err}, {31'h0, err_exp});
    bus_write(8'hFF, 8'h00);
    #(4*T);
    chk("t5_err_clr", {31'h0, bus_err}, 0);
    @(negedge clk);
    #10;
    rst_n = 1'b0;
    #(2*T);
    rst_n = 1'b1;
    #(2*T);
    drv_en = 1'b1;
    drv_val = 8'h77;
    write = 1'b0;
    #(3*T);
    write = 1'b1;
    #(4*T);
    chk("t6_no_we", we_cnt, 7);
    chk("t6_err", {31'h0, bus_err}, {31'h0, err_exp});
    #(2*T);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
